// File: rtl/i2c_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : i2c_pkg
//  Purpose  : Shared states, register map and read-map helper for the
//             angle-encoder I2C target.
//  Revision : 1.0
// ============================================================================
package i2c_pkg;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_ADDR     = 4'd1,
        ST_ADDR_ACK = 4'd2,
        ST_PTR      = 4'd3,
        ST_PTR_ACK  = 4'd4,
        ST_WR_DATA  = 4'd5,
        ST_WR_ACK   = 4'd6,
        ST_RD_DATA  = 4'd7,
        ST_RD_ACK   = 4'd8,
        ST_IGNORE   = 4'd9
    } i2c_state_t;

    localparam logic [6:0] DEFAULT_DEV_ADDR = 7'h36;

    localparam logic [7:0] REG_STATUS      = 8'h0B;
    localparam logic [7:0] REG_RAW_ANGLE_H = 8'h0C;
    localparam logic [7:0] REG_RAW_ANGLE_L = 8'h0D;
    localparam logic [7:0] REG_ANGLE_H     = 8'h0E;
    localparam logic [7:0] REG_ANGLE_L     = 8'h0F;

    function automatic logic [7:0] read_reg(
        input logic [7:0]  addr,
        input logic [11:0] ang,
        input logic [2:0]  mag
    );
        logic [7:0] v;
        case (addr)
            REG_STATUS:                   v = {2'b00, mag, 3'b000};
            REG_RAW_ANGLE_H, REG_ANGLE_H: v = {4'h0, ang[11:8]};
            REG_RAW_ANGLE_L, REG_ANGLE_L: v = ang[7:0];
            default:                      v = 8'h00;
        endcase
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/i2c_line_sync.sv
`default_nettype none
// ============================================================================
//  Module   : i2c_line_sync
//  Purpose  : SCL/SDA synchronizers with edge and START/STOP detection.
//  Revision : 1.0
// ============================================================================
module i2c_line_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic reset_n,
    input  logic scl,
    input  logic sda_in,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic sda_s
);

    logic [SYNC_STAGES-1:0] r_scl_sync;
    logic [SYNC_STAGES-1:0] r_sda_sync;
    logic                   r_scl_d;
    logic                   r_sda_d;
    logic                   w_scl_s;
    logic                   w_sda_rise;
    logic                   w_sda_fall;

    // Flops reset to the idle-bus level so reset release creates no edges.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_scl_d    <= 1'b1;
            r_sda_d    <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl};
            r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda_in};
            r_scl_d    <= w_scl_s;
            r_sda_d    <= sda_s;
        end
    end

    assign w_scl_s    = r_scl_sync[SYNC_STAGES-1];
    assign sda_s      = r_sda_sync[SYNC_STAGES-1];
    assign scl_rise   = w_scl_s & ~r_scl_d;
    assign scl_fall   = ~w_scl_s & r_scl_d;
    assign w_sda_rise = sda_s & ~r_sda_d;
    assign w_sda_fall = ~sda_s & r_sda_d;

    // SCL must be stable high across the SDA edge; a coincident SCL edge is data.
    assign start_det  = w_sda_fall & w_scl_s & r_scl_d;
    assign stop_det   = w_sda_rise & w_scl_s & r_scl_d;

endmodule
`default_nettype wire

// File: rtl/i2c_encoder_target.sv
`default_nettype none
// ============================================================================
//  Module   : i2c_encoder_target
//  Purpose  : I2C target emulating a 12-bit magnetic angle encoder.
//  Revision : 1.0
// ============================================================================
module i2c_encoder_target
    import i2c_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR    = DEFAULT_DEV_ADDR,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        scl,
    input  logic        sda_in,
    output logic        sda_drive_low,
    input  logic [11:0] angle,
    input  logic [2:0]  magnet_status,
    output logic [7:0]  reg_wr_addr,
    output logic [7:0]  reg_wr_data,
    output logic        reg_wr_valid,
    output logic        busy
);

    logic w_scl_rise, w_scl_fall, w_start, w_stop, w_sda_s;

    i2c_line_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_line_sync (
        .clock     (clock),
        .reset_n   (reset_n),
        .scl       (scl),
        .sda_in    (sda_in),
        .scl_rise  (w_scl_rise),
        .scl_fall  (w_scl_fall),
        .start_det (w_start),
        .stop_det  (w_stop),
        .sda_s     (w_sda_s)
    );

    i2c_state_t  r_state,      w_state_nxt;
    logic [3:0]  r_bit_cnt,    w_cnt_nxt;
    logic [7:0]  r_shift,      w_shift_nxt;
    logic [7:0]  r_ptr,        w_ptr_nxt;
    logic        r_rw,         w_rw_nxt;
    logic        r_busy,       w_busy_nxt;
    logic        r_sda_drive,  w_drive_nxt;
    logic [11:0] r_snap_angle, w_snap_angle_nxt;
    logic [2:0]  r_snap_mag,   w_snap_mag_nxt;
    logic        r_wr_valid,   w_wr_valid_nxt;
    logic [7:0]  r_wr_addr,    w_wr_addr_nxt;
    logic [7:0]  r_wr_data,    w_wr_data_nxt;
    logic        r_fall_d;
    logic [7:0]  w_ptr_inc;
    logic [7:0]  w_rd_byte;
    logic [7:0]  w_shift_in;
    logic [2:0]  w_bit_idx;

    assign w_ptr_inc  = r_ptr + 8'd1;
    assign w_shift_in = {r_shift[6:0], w_sda_s};
    assign w_bit_idx  = 3'd7 - r_bit_cnt[2:0];
    // In RD_ACK the byte being prepared is the one after the current pointer.
    assign w_rd_byte  = read_reg((r_state == ST_RD_ACK) ? w_ptr_inc : r_ptr,
                                 r_snap_angle, r_snap_mag);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_bit_cnt    <= 4'd0;
            r_shift      <= 8'h00;
            r_ptr        <= 8'h00;
            r_rw         <= 1'b0;
            r_busy       <= 1'b0;
            r_sda_drive  <= 1'b0;
            r_snap_angle <= 12'h000;
            r_snap_mag   <= 3'b000;
            r_wr_valid   <= 1'b0;
            r_wr_addr    <= 8'h00;
            r_wr_data    <= 8'h00;
            r_fall_d     <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_bit_cnt    <= w_cnt_nxt;
            r_shift      <= w_shift_nxt;
            r_ptr        <= w_ptr_nxt;
            r_rw         <= w_rw_nxt;
            r_busy       <= w_busy_nxt;
            r_sda_drive  <= w_drive_nxt;
            r_snap_angle <= w_snap_angle_nxt;
            r_snap_mag   <= w_snap_mag_nxt;
            r_wr_valid   <= w_wr_valid_nxt;
            r_wr_addr    <= w_wr_addr_nxt;
            r_wr_data    <= w_wr_data_nxt;
            r_fall_d     <= w_scl_fall;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_bit_cnt;
        w_shift_nxt      = r_shift;
        w_ptr_nxt        = r_ptr;
        w_rw_nxt         = r_rw;
        w_busy_nxt       = r_busy;
        w_drive_nxt      = r_sda_drive;
        w_snap_angle_nxt = r_snap_angle;
        w_snap_mag_nxt   = r_snap_mag;
        w_wr_valid_nxt   = 1'b0;
        w_wr_addr_nxt    = r_wr_addr;
        w_wr_data_nxt    = r_wr_data;

        if (w_stop) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = 4'd0;
            w_drive_nxt = 1'b0;
            w_busy_nxt  = 1'b0;
        end else if (w_start) begin
            w_state_nxt = ST_ADDR;
            w_cnt_nxt   = 4'd0;
            w_drive_nxt = 1'b0;
        end else begin
            // Inputs are sampled on scl_rise; SDA only changes on the delayed fall.
            case (r_state)
                ST_ADDR, ST_PTR, ST_WR_DATA: begin
                    if (w_scl_rise) begin
                        w_shift_nxt = w_shift_in;
                        w_cnt_nxt   = r_bit_cnt + 4'd1;
                        if (r_state == ST_WR_DATA && r_bit_cnt == 4'd7) begin
                            w_wr_valid_nxt = 1'b1;
                            w_wr_addr_nxt  = r_ptr;
                            w_wr_data_nxt  = w_shift_in;
                        end
                    end
                    if (r_fall_d && r_bit_cnt == 4'd8) begin
                        w_drive_nxt = 1'b1;
                        case (r_state)
                            ST_ADDR: begin
                                if (r_shift[7:1] == DEV_ADDR) begin
                                    w_state_nxt      = ST_ADDR_ACK;
                                    w_busy_nxt       = 1'b1;
                                    w_rw_nxt         = r_shift[0];
                                    w_snap_angle_nxt = angle;
                                    w_snap_mag_nxt   = magnet_status;
                                end else begin
                                    w_state_nxt = ST_IGNORE;
                                    w_busy_nxt  = 1'b0;
                                    w_drive_nxt = 1'b0;
                                end
                            end
                            ST_PTR: begin
                                w_ptr_nxt   = r_shift;
                                w_state_nxt = ST_PTR_ACK;
                            end
                            default: w_state_nxt = ST_WR_ACK;
                        endcase
                    end
                end
                ST_ADDR_ACK: begin
                    if (r_fall_d) begin
                        w_cnt_nxt = 4'd0;
                        if (r_rw) begin
                            w_state_nxt = ST_RD_DATA;
                            w_shift_nxt = w_rd_byte;
                            w_drive_nxt = ~w_rd_byte[7];
                        end else begin
                            w_state_nxt = ST_PTR;
                            w_drive_nxt = 1'b0;
                        end
                    end
                end
                ST_PTR_ACK, ST_WR_ACK: begin
                    if (r_fall_d) begin
                        w_state_nxt = ST_WR_DATA;
                        w_cnt_nxt   = 4'd0;
                        w_drive_nxt = 1'b0;
                        if (r_state == ST_WR_ACK) begin
                            w_ptr_nxt = w_ptr_inc;
                        end
                    end
                end
                ST_RD_DATA: begin
                    if (w_scl_rise) begin
                        w_cnt_nxt = r_bit_cnt + 4'd1;
                    end
                    if (r_fall_d) begin
                        if (r_bit_cnt == 4'd8) begin
                            w_state_nxt = ST_RD_ACK;
                            w_drive_nxt = 1'b0;
                        end else begin
                            w_drive_nxt = ~r_shift[w_bit_idx];
                        end
                    end
                end
                ST_RD_ACK: begin
                    if (w_scl_rise && w_sda_s) begin
                        w_state_nxt = ST_IGNORE;
                    end else if (r_fall_d) begin
                        w_state_nxt = ST_RD_DATA;
                        w_cnt_nxt   = 4'd0;
                        w_ptr_nxt   = w_ptr_inc;
                        w_shift_nxt = w_rd_byte;
                        w_drive_nxt = ~w_rd_byte[7];
                    end
                end
                ST_IGNORE: w_drive_nxt = 1'b0;
                default:   w_state_nxt = ST_IDLE;
            endcase
        end
    end

    assign sda_drive_low = r_sda_drive;
    assign reg_wr_valid  = r_wr_valid;
    assign reg_wr_addr   = r_wr_addr;
    assign reg_wr_data   = r_wr_data;
    assign busy          = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_i2c_encoder_target.sv
`default_nettype none
// ============================================================================
//  Module   : tb_i2c_encoder_target
//  Purpose  : Bit-banged I2C initiator with a register-image reference model.
//  Revision : 1.0
// ============================================================================
module tb_i2c_encoder_target;

    localparam int QC = 8;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        scl = 1'b1;
    logic        m_low = 1'b0;
    logic [11:0] angle = 12'h000;
    logic [2:0]  magnet_status = 3'b000;
    logic        sda_in;
    logic        sda_drive_low;
    logic [7:0]  reg_wr_addr;
    logic [7:0]  reg_wr_data;
    logic        reg_wr_valid;
    logic        busy;

    // Open-drain bus: either side pulling low wins.
    assign sda_in = ~(m_low | sda_drive_low);

    always #5 clock = ~clock;

    i2c_encoder_target dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .scl           (scl),
        .sda_in        (sda_in),
        .sda_drive_low (sda_drive_low),
        .angle         (angle),
        .magnet_status (magnet_status),
        .reg_wr_addr   (reg_wr_addr),
        .reg_wr_data   (reg_wr_data),
        .reg_wr_valid  (reg_wr_valid),
        .busy          (busy)
    );

    int          n_checks = 0;
    int          n_fail = 0;
    int          drive_cnt = 0;
    int          busy_cnt = 0;
    logic [15:0] obs_q[$];
    logic [15:0] exp_q[$];
    logic [7:0]  m_ptr = 8'h00;

    always @(negedge clock) begin
        if (reg_wr_valid) obs_q.push_back({reg_wr_addr, reg_wr_data});
        if (sda_drive_low) drive_cnt++;
        if (busy) busy_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] model_byte(input logic [7:0] a, input logic [11:0] ang,
                                              input logic [2:0] mag);
        logic [7:0] img [256];
        for (int i = 0; i < 256; i++) img[i] = 8'h00;
        img[11] = 8'(32'(mag) * 8);
        img[12] = 8'(32'(ang) / 256);
        img[13] = 8'(32'(ang) % 256);
        img[14] = img[12];
        img[15] = img[13];
        return img[a];
    endfunction

    task automatic qw();
        repeat (QC) @(posedge clock);
        #1;
    endtask

    task automatic bus_start();
        if (scl) begin
            m_low = 1'b1; qw();
            scl = 1'b0;   qw();
        end else begin
            m_low = 1'b0; qw();
            scl = 1'b1;   qw();
            m_low = 1'b1; qw();
            scl = 1'b0;   qw();
        end
    endtask

    task automatic bus_stop();
        m_low = 1'b1; qw();
        scl = 1'b1;   qw();
        m_low = 1'b0; qw();
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) begin
            m_low = ~b[i]; qw();
            scl = 1'b1; qw(); qw();
            scl = 1'b0; qw();
        end
        m_low = 1'b0; qw();
        scl = 1'b1; qw();
        ack = ~sda_in; qw();
        scl = 1'b0; qw();
    endtask

    task automatic read_byte(input logic give_ack, output logic [7:0] d);
        m_low = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            qw();
            scl = 1'b1; qw();
            d[i] = sda_in; qw();
            scl = 1'b0; qw();
        end
        m_low = give_ack; qw();
        scl = 1'b1; qw(); qw();
        scl = 1'b0; qw();
    endtask

    task automatic check_strobes();
        check_eq("wr_strobe_count", obs_q.size(), exp_q.size());
        while (obs_q.size() > 0 && exp_q.size() > 0)
            check_eq("wr_strobe", obs_q.pop_front(), exp_q.pop_front());
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic write_txn(input logic [7:0] p, input int n, input logic [31:0] d);
        logic ack;
        bus_start();
        send_byte(8'h6C, ack); check_eq("wr_addr_ack", ack, 1);
        send_byte(p, ack);     check_eq("ptr_ack", ack, 1);
        m_ptr = p;
        for (int i = 0; i < n; i++) begin
            send_byte(d[8*i +: 8], ack);
            check_eq("wr_data_ack", ack, 1);
            exp_q.push_back({m_ptr, d[8*i +: 8]});
            m_ptr = m_ptr + 8'd1;
        end
        bus_stop();
        check_eq("busy_after_stop", busy, 0);
        check_strobes();
    endtask

    // Optionally sets the pointer then reads n bytes via repeated START; the last byte is NACKed.
    task automatic read_txn(input bit set_ptr, input logic [7:0] p, input int n, input bit wiggle);
        logic        ack;
        logic [7:0]  d;
        logic [11:0] snap_a;
        logic [2:0]  snap_m;
        if (set_ptr) begin
            bus_start();
            send_byte(8'h6C, ack); check_eq("wr_addr_ack", ack, 1);
            send_byte(p, ack);     check_eq("ptr_ack", ack, 1);
            m_ptr = p;
        end
        bus_start();
        snap_a = angle;
        snap_m = magnet_status;
        send_byte(8'h6D, ack); check_eq("rd_addr_ack", ack, 1);
        check_eq("busy_on", busy, 1);
        for (int i = 0; i < n; i++) begin
            read_byte(i != n - 1, d);
            check_eq("rd_data", d, model_byte(m_ptr, snap_a, snap_m));
            if (i != n - 1) m_ptr = m_ptr + 8'd1;
            if (wiggle) angle = angle + 12'd1;
        end
        check_eq("rd_release", sda_drive_low, 0);
        bus_stop();
        check_eq("busy_after_stop", busy, 0);
    endtask

    initial begin
        logic       ack;
        logic [7:0] p;
        int         kind;

        repeat (4) @(posedge clock);
        #1;
        check_eq("rst_sda", sda_drive_low, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_valid", reg_wr_valid, 0);
        check_eq("rst_wr_addr", reg_wr_addr, 0);
        check_eq("rst_wr_data", reg_wr_data, 0);
        reset_n = 1'b1;
        qw();

        // Pointer write, repeated START, two-byte read.
        angle = 12'hA5C;
        read_txn(1, 8'h0C, 2, 0);

        // Foreign address: no ACK, no drive, no busy, no strobe.
        drive_cnt = 0;
        busy_cnt  = 0;
        obs_q.delete();
        bus_start();
        send_byte(8'h70, ack); check_eq("ign_addr_ack", ack, 0);
        send_byte(8'h0C, ack); check_eq("ign_data_ack", ack, 0);
        bus_stop();
        check_eq("ign_drive", drive_cnt, 0);
        check_eq("ign_busy", busy_cnt, 0);
        check_strobes();

        // Pointer wrap and write strobes.
        write_txn(8'hFF, 2, 32'h0000_2211);
        read_txn(0, 8'h00, 1, 0);
        write_txn(8'h0D, 2, 32'h0000_BEEF);
        angle = 12'h7E4;
        read_txn(0, 8'h00, 2, 0);
        write_txn(8'h33, 0, 32'h0);

        // Snapshot coherence across a changing angle.
        angle = 12'h0FF;
        read_txn(1, 8'h0C, 2, 1);

        magnet_status = 3'b100;
        read_txn(1, 8'h0B, 1, 0);
        read_txn(1, 8'h40, 1, 0);

        // Asynchronous reset while the target drives a zero bit.
        angle = 12'h3C5;
        bus_start();
        send_byte(8'h6C, ack);
        send_byte(8'h0C, ack);
        bus_start();
        send_byte(8'h6D, ack); check_eq("rst_rd_addr_ack", ack, 1);
        m_low = 1'b0;
        for (int i = 0; i < 3; i++) begin
            qw(); scl = 1'b1; qw(); qw(); scl = 1'b0;
        end
        qw(); scl = 1'b1; qw();
        check_eq("rst_pre_drive", sda_drive_low, 1);
        @(posedge clock);
        #3 reset_n = 1'b0;
        #1 check_eq("rst_async_release", sda_drive_low, 0);
        check_eq("rst_async_busy", busy, 0);
        repeat (4) @(posedge clock);
        #1 reset_n = 1'b1;
        m_ptr = 8'h00;
        qw();
        read_txn(0, 8'h00, 1, 0);
        read_txn(1, 8'h0C, 1, 0);

        for (int it = 0; it < 14; it++) begin
            angle         = 12'($urandom);
            magnet_status = 3'($urandom);
            kind          = $urandom_range(0, 2);
            p = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'(8'h0A + $urandom_range(0, 6));
            case (kind)
                0:       write_txn(p, $urandom_range(0, 3), $urandom);
                1:       read_txn(1, p, $urandom_range(1, 3), 1'($urandom_range(0, 1)));
                default: read_txn(0, 8'h00, $urandom_range(1, 3), 0);
            endcase
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
